writeback_unit: RTL and testbench

Completion-side counterpart of the execute stage. It accepts results from the arithmetic, memory and terminate pipelines and drives the physical register file write ports (cmplt_regs/cmplt_vals). It funnels ROB completion notices through a 2-per-cycle completion FIFO and emits a registered branch/terminate redirect. It is the only writer of the register file and the only source of ROB "done" marks.

---
 rtl/writeback_unit_if.sv | 48 ++++
 rtl/writeback_unit.sv | 113 +++++++++++
 tb/tb_writeback_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Result buses from the execute pipelines into the writeback unit, and the
// register-file / ROB / redirect buses it drives.
interface writeback_unit_if #(
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 5
);
  logic                   arith_valid;
  logic [ROB_IDX_W-1:0]   arith_rob;
  logic [PREG_W-1:0]      arith_dest;
  logic [PREG_W-1:0]      arith_flag_reg;
  logic [7:0]             arith_val;
  logic [7:0]             arith_flags;

  logic                   mem_valid;
  logic                   mem_ready;
  logic [ROB_IDX_W-1:0]   mem_rob;
  logic [PREG_W-1:0]      mem_dest;
  logic [7:0]             mem_data;

  logic                   term_valid;
  logic [ROB_IDX_W-1:0]   term_rob;
  logic [15:0]            term_addr;

  logic [6*PREG_W-1:0]    cmplt_regs;
  logic [47:0]            cmplt_vals;
  logic [1:0]             rob_done_valid;
  logic [2*ROB_IDX_W-1:0] rob_done_entries;
  logic                   redirect_valid;
  logic [15:0]            redirect_addr;

  modport master (
    output arith_valid, arith_rob, arith_dest, arith_flag_reg, arith_val, arith_flags,
    output mem_valid, mem_rob, mem_dest, mem_data,
    output term_valid, term_rob, term_addr,
    input  mem_ready,
    input  cmplt_regs, cmplt_vals, rob_done_valid, rob_done_entries,
    input  redirect_valid, redirect_addr
  );

  modport slave (
    input  arith_valid, arith_rob, arith_dest, arith_flag_reg, arith_val, arith_flags,
    input  mem_valid, mem_rob, mem_dest, mem_data,
    input  term_valid, term_rob, term_addr,
    output mem_ready,
    output cmplt_regs, cmplt_vals, rob_done_valid, rob_done_entries,
    output redirect_valid, redirect_addr
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: registered register-file writes, a 3-push / 2-pop ROB
// completion FIFO with same-cycle bypass, and a registered redirect pulse.
module writeback_unit #(
  parameter int CQ_DEPTH  = 8,
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  writeback_unit_if.slave      bus
);
  localparam int PTR_W = $clog2(CQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     head, tail;
  logic [CNT_W-1:0]     count, count_next;
  logic [CNT_W:0]       avail;
  logic [ROB_IDX_W-1:0] fifo_mem [CQ_DEPTH];
  logic [ROB_IDX_W-1:0] push_e [3];
  logic [ROB_IDX_W-1:0] pop_e [2];
  logic [1:0]           n_push, n_pop;
  logic                 mem_fire;

  // Ready depends only on the registered occupancy, never on a valid input.
  assign bus.mem_ready = rst && (count <= CNT_W'(CQ_DEPTH - 3));
  assign mem_fire      = bus.mem_valid && bus.mem_ready;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so n_push can be read back after each increment and no
  // latch is inferred.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < 3; i++) push_e[i] = '0;
    if (bus.arith_valid) begin
      push_e[n_push] = bus.arith_rob;
      n_push         = n_push + 2'd1;
    end
    if (mem_fire) begin
      push_e[n_push] = bus.mem_rob;
      n_push         = n_push + 2'd1;
    end
    if (bus.term_valid) begin
      push_e[n_push] = bus.term_rob;
      n_push         = n_push + 2'd1;
    end
  end

  // Oldest stored entries go first; an empty or single-entry FIFO is topped
  // up from this cycle's pushes.
  always_comb begin
    avail = (CNT_W+1)'(count) + (CNT_W+1)'(n_push);
    n_pop = (avail >= (CNT_W+1)'(2)) ? 2'd2 : avail[1:0];
    if (count != '0) pop_e[0] = fifo_mem[head];
    else             pop_e[0] = push_e[0];
    if (count >= CNT_W'(2))      pop_e[1] = fifo_mem[head + PTR_W'(1)];
    else if (count == CNT_W'(1)) pop_e[1] = push_e[0];
    else                         pop_e[1] = push_e[1];
    count_next = count + CNT_W'(n_push) - CNT_W'(n_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count_next;
    end
  end

  // NOTE: the storage array has no reset; count and head decide which slots
  // are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (i < int'(n_push)) fifo_mem[tail + PTR_W'(i)] <= push_e[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.cmplt_regs       <= '0;
      bus.cmplt_vals       <= '0;
      bus.rob_done_valid   <= '0;
      bus.rob_done_entries <= '0;
      bus.redirect_valid   <= 1'b0;
      bus.redirect_addr    <= '0;
    end else begin
      bus.cmplt_regs <= {(3*PREG_W)'(0),
                         mem_fire        ? bus.mem_dest       : '0,
                         bus.arith_valid ? bus.arith_flag_reg : '0,
                         bus.arith_valid ? bus.arith_dest     : '0};
      bus.cmplt_vals <= {24'h0,
                         mem_fire        ? bus.mem_data    : 8'h0,
                         bus.arith_valid ? bus.arith_flags : 8'h0,
                         bus.arith_valid ? bus.arith_val   : 8'h0};
      bus.rob_done_valid   <= {n_pop == 2'd2, n_pop != 2'd0};
      bus.rob_done_entries <= {(n_pop == 2'd2) ? pop_e[1] : '0,
                               (n_pop != 2'd0) ? pop_e[0] : '0};
      bus.redirect_valid   <= bus.term_valid;
      if (bus.term_valid) bus.redirect_addr <= bus.term_addr;
    end
  end

  // Net growth is at most one entry per cycle and mem is gated early.
  always @(posedge clk) begin
    if (rst) assert (int'(count_next) <= CQ_DEPTH)
      else $error("completion FIFO occupancy %0d exceeds depth", count_next);
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random
// traffic against a queue-based completion model.
module tb_writeback_unit;
  localparam int CQ_DEPTH = 8;

  typedef struct {
    logic       av;
    logic [4:0] arob, adest, aflag;
    logic [7:0] aval, aflags;
    logic       mv;
    logic [4:0] mrob, mdest;
    logic [7:0] mdata;
    logic       tv;
    logic [4:0] trob;
    logic [15:0] taddr;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  writeback_unit_if #(.ROB_IDX_W(5), .PREG_W(5)) bus ();

  writeback_unit #(.CQ_DEPTH(CQ_DEPTH), .ROB_IDX_W(5), .PREG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          passed = 0;
  int          total  = 0;
  logic [4:0]  q [$];
  logic [15:0] exp_raddr = '0;
  logic [4:0]  next_rob = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.arith_valid    = s.av;
    bus.arith_rob      = s.arob;
    bus.arith_dest     = s.adest;
    bus.arith_flag_reg = s.aflag;
    bus.arith_val      = s.aval;
    bus.arith_flags    = s.aflags;
    bus.mem_valid      = s.mv;
    bus.mem_rob        = s.mrob;
    bus.mem_dest       = s.mdest;
    bus.mem_data       = s.mdata;
    bus.term_valid     = s.tv;
    bus.term_rob       = s.trob;
    bus.term_addr      = s.taddr;
  endtask

  function automatic stim_t rand_stim(input logic av, input logic mv, input logic tv);
    stim_t s;
    s = idle();
    s.av = av; s.mv = mv; s.tv = tv;
    s.arob = 5'($urandom); s.mrob = 5'($urandom); s.trob = 5'($urandom);
    s.adest = 5'($urandom); s.aflag = 5'($urandom); s.mdest = 5'($urandom);
    s.aval = 8'($urandom); s.aflags = 8'($urandom); s.mdata = 8'($urandom);
    s.taddr = 16'($urandom);
    return s;
  endfunction

  // One cycle: drive at the falling edge, predict, check after the rising edge.
  task automatic step(input stim_t s);
    logic        ready_exp;
    logic        mfire;
    int          npop;
    logic [4:0]  e [2];
    logic [29:0] er;
    logic [47:0] ev;
    logic [1:0]  dv;
    @(negedge clk);
    drive(s);
    ready_exp = (q.size() <= CQ_DEPTH - 3);
    check("mem_ready", 64'(bus.mem_ready), 64'(ready_exp));
    mfire = s.mv && ready_exp;
    if (s.av) q.push_back(s.arob);
    if (mfire) q.push_back(s.mrob);
    if (s.tv) q.push_back(s.trob);
    npop = (q.size() < 2) ? q.size() : 2;
    e[0] = '0; e[1] = '0;
    for (int k = 0; k < npop; k++) e[k] = q.pop_front();
    dv = (npop == 2) ? 2'b11 : (npop == 1) ? 2'b01 : 2'b00;
    er = '0; ev = '0;
    if (s.av) begin
      er[4:0] = s.adest; er[9:5] = s.aflag;
      ev[7:0] = s.aval;  ev[15:8] = s.aflags;
    end
    if (mfire) begin
      er[14:10] = s.mdest; ev[23:16] = s.mdata;
    end
    if (s.tv) exp_raddr = s.taddr;
    @(posedge clk);
    #1;
    check("done_valid", 64'(bus.rob_done_valid), 64'(dv));
    if (npop > 0) check("done_entry0", 64'(bus.rob_done_entries[4:0]), 64'(e[0]));
    if (npop > 1) check("done_entry1", 64'(bus.rob_done_entries[9:5]), 64'(e[1]));
    check("cmplt_regs", 64'(bus.cmplt_regs), 64'(er));
    check("cmplt_vals", 64'(bus.cmplt_vals), 64'(ev));
    check("redirect_valid", 64'(bus.redirect_valid), 64'(s.tv));
    check("redirect_addr", 64'(bus.redirect_addr), 64'(exp_raddr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  64'(bus.mem_ready), 64'(0));
    check({tag, "_dvalid"}, 64'(bus.rob_done_valid), 64'(0));
    check({tag, "_dent"},   64'(bus.rob_done_entries), 64'(0));
    check({tag, "_regs"},   64'(bus.cmplt_regs), 64'(0));
    check({tag, "_vals"},   64'(bus.cmplt_vals), 64'(0));
    check({tag, "_rvalid"}, 64'(bus.redirect_valid), 64'(0));
    check({tag, "_raddr"},  64'(bus.redirect_addr), 64'(0));
  endtask

  initial begin
    stim_t s;

    // Reset held with every valid asserted.
    drive(rand_stim(1'b1, 1'b1, 1'b1));
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    drive(idle());
    rst = 1'b1;
    #1;
    check("post_reset_ready", 64'(bus.mem_ready), 64'(1));
    check("post_reset_dvalid", 64'(bus.rob_done_valid), 64'(0));

    // Single arith result.
    s = idle();
    s.av = 1'b1; s.arob = 5'd3; s.adest = 5'd7; s.aflag = 5'd8;
    s.aval = 8'h5A; s.aflags = 8'h02;
    step(s);
    step(idle());

    // Triple issue: two completions next cycle, the third one after.
    s = idle();
    s.av = 1'b1; s.arob = 5'd1; s.adest = 5'd2; s.aflag = 5'd3; s.aval = 8'h11;
    s.mv = 1'b1; s.mrob = 5'd2; s.mdest = 5'd9; s.mdata = 8'hC3;
    s.tv = 1'b1; s.trob = 5'd4; s.taddr = 16'h1234;
    step(s);
    step(idle());
    step(idle());

    // Backpressure: sustained triple issue until mem_ready drops, then drain.
    for (int i = 0; i < 9; i++) begin
      s = rand_stim(1'b1, 1'b1, 1'b1);
      s.arob = next_rob; s.mrob = next_rob + 5'd1; s.trob = next_rob + 5'd2;
      next_rob = next_rob + 5'd3;
      step(s);
    end
    for (int i = 0; i < 6; i++) step(idle());

    // Wrap-around: 20 arith-only results with sequential ROB entries.
    for (int i = 0; i < 20; i++) begin
      s = rand_stim(1'b1, 1'b0, 1'b0);
      s.arob = 5'(i);
      step(s);
    end
    step(idle());

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      s = rand_stim(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      step(s);
    end
    for (int i = 0; i < 6; i++) step(idle());

    // Reset mid-drain: build occupancy of 5, then pulse reset.
    for (int i = 0; i < 5; i++) step(rand_stim(1'b1, 1'b1, 1'b1));
    @(negedge clk);
    drive(idle());
    rst = 1'b0;
    q.delete();
    exp_raddr = '0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(idle());
    s = idle();
    s.av = 1'b1; s.arob = 5'd17; s.adest = 5'd5; s.aval = 8'hA5;
    step(s);
    step(idle());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
